// File: rtl/stream_accel_engine.sv
// stream_accel_engine
//   Streaming compute stage between the HPS-to-FPGA FIFO source and the
//   FPGA-to-HPS FIFO sink. A packet is a header word
//   (opcode = in_data[31:24], N = in_data[LEN_W-1:0]) followed by N data words.
//   Reductions (SUM/XOR/MAX/MIN) return one result word. ECHO_INC returns each
//   word plus one. Any other opcode consumes N words and returns a zero word
//   with out_error[0] set.
//
//   Optional build macro STREAM_ACCEL_TIMESTAMP_EN: adds a 32-bit cycle counter
//   (header accept to last data accept) that is emitted as one extra word
//   (channel 0xFF) after the result word or after the last echo word.
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   in_valid/in_data/in_channel/      Avalon-ST sink, ready latency 0
//   in_error/in_ready                 (in_channel is ignored)
//   out_valid/out_data/out_channel/   Avalon-ST source, ready latency 0
//   out_error/out_ready
//   busy                              FSM not in IDLE
//   pkt_count                         completed packets, wraps
module stream_accel_engine #(
    parameter int DATA_W = 32,
    parameter int CH_W   = 8,
    parameter int ERR_W  = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_channel,
    input  logic [ERR_W-1:0]  in_error,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_channel,
    output logic [ERR_W-1:0]  out_error,
    input  logic              out_ready,
    output logic              busy,
    output logic [LEN_W-1:0]  pkt_count
);
    localparam logic [7:0] OP_SUM  = 8'h01;
    localparam logic [7:0] OP_XOR  = 8'h02;
    localparam logic [7:0] OP_MAX  = 8'h03;
    localparam logic [7:0] OP_MIN  = 8'h04;
    localparam logic [7:0] OP_ECHO = 8'h10;

    typedef enum logic [2:0] {
        S_IDLE, S_ACCUM, S_RESULT, S_ECHO, S_DRAIN, S_DONE, S_TSTAMP
    } state_t;

    state_t            state;
    logic [7:0]        opcode;
    logic [LEN_W-1:0]  remain;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_nxt;
    logic              err_sticky;
    logic              run_q;      // keeps in_ready low in the first cycle after reset
    logic              in_fire;
    logic              last_word;
    logic              word_err;
    logic [7:0]        hdr_op;
    logic [LEN_W-1:0]  hdr_len;
    logic              unused_in;
`ifdef STREAM_ACCEL_TIMESTAMP_EN
    logic [31:0]       cyc;
`endif

    function automatic logic op_known(input logic [7:0] op);
        return op inside {OP_SUM, OP_XOR, OP_MAX, OP_MIN, OP_ECHO};
    endfunction

    // Identity element: all-ones for MIN, zero for everything else.
    function automatic logic [DATA_W-1:0] ident(input logic [7:0] op);
        return {DATA_W{op == OP_MIN}};
    endfunction

    assign hdr_op    = in_data[31:24];
    assign hdr_len   = in_data[LEN_W-1:0];
    assign in_fire   = in_valid && in_ready;
    assign last_word = (remain == LEN_W'(1));
    assign word_err  = |in_error;
    assign busy      = (state != S_IDLE);
    assign unused_in = ^in_channel;

    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_IDLE, S_ACCUM: in_ready = run_q;
            S_ECHO:          in_ready = !out_valid || out_ready;
            default:         in_ready = 1'b0;
        endcase
    end

    // Invalid opcodes fall through to zero, so their accumulator stays 0.
    always_comb begin
        acc_nxt = '0;
        case (opcode)
            OP_SUM:  acc_nxt = acc + in_data;
            OP_XOR:  acc_nxt = acc ^ in_data;
            OP_MAX:  acc_nxt = (in_data > acc) ? in_data : acc;
            OP_MIN:  acc_nxt = (in_data < acc) ? in_data : acc;
            default: acc_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            opcode      <= '0;
            remain      <= '0;
            acc         <= '0;
            err_sticky  <= 1'b0;
            run_q       <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
            out_error   <= '0;
            pkt_count   <= '0;
`ifdef STREAM_ACCEL_TIMESTAMP_EN
            cyc         <= '0;
`endif
        end else begin
            run_q <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (in_fire) begin
                        opcode     <= hdr_op;
                        remain     <= hdr_len;
                        acc        <= ident(hdr_op);
                        err_sticky <= 1'b0;
`ifdef STREAM_ACCEL_TIMESTAMP_EN
                        cyc        <= '0;
`endif
                        if (hdr_len == '0) begin
                            if (hdr_op == OP_ECHO) begin
                                state <= S_DONE;
                            end else begin
                                state       <= S_RESULT;
                                out_valid   <= 1'b1;
                                out_data    <= ident(hdr_op);
                                out_channel <= CH_W'(hdr_op);
                                out_error   <= ERR_W'({1'b0, !op_known(hdr_op)});
                            end
                        end else begin
                            state <= (hdr_op == OP_ECHO) ? S_ECHO : S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
`ifdef STREAM_ACCEL_TIMESTAMP_EN
                    cyc <= cyc + 32'd1;
`endif
                    if (in_fire) begin
                        acc    <= acc_nxt;
                        remain <= remain - LEN_W'(1);
                        if (word_err) err_sticky <= 1'b1;
                        // Result is loaded on the last accept so it shows next cycle.
                        if (last_word) begin
                            state       <= S_RESULT;
                            out_valid   <= 1'b1;
                            out_data    <= acc_nxt;
                            out_channel <= CH_W'(opcode);
                            out_error   <= ERR_W'({err_sticky || word_err, !op_known(opcode)});
                        end
                    end
                end
                S_RESULT: begin
                    if (out_ready) begin
`ifdef STREAM_ACCEL_TIMESTAMP_EN
                        out_data    <= DATA_W'(cyc);
                        out_channel <= CH_W'(8'hFF);
                        out_error   <= '0;
                        state       <= S_TSTAMP;
`else
                        out_valid   <= 1'b0;
                        state       <= S_DONE;
`endif
                    end
                end
                S_ECHO: begin
`ifdef STREAM_ACCEL_TIMESTAMP_EN
                    cyc <= cyc + 32'd1;
`endif
                    if (in_fire) begin
                        out_valid   <= 1'b1;
                        out_data    <= in_data + DATA_W'(1);
                        out_channel <= CH_W'(OP_ECHO);
                        out_error   <= ERR_W'({word_err, 1'b0});
                        remain      <= remain - LEN_W'(1);
                        if (last_word) state <= S_DRAIN;
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (!out_valid || out_ready) begin
`ifdef STREAM_ACCEL_TIMESTAMP_EN
                        out_valid   <= 1'b1;
                        out_data    <= DATA_W'(cyc);
                        out_channel <= CH_W'(8'hFF);
                        out_error   <= '0;
                        state       <= S_TSTAMP;
`else
                        out_valid   <= 1'b0;
                        state       <= S_DONE;
`endif
                    end
                end
`ifdef STREAM_ACCEL_TIMESTAMP_EN
                S_TSTAMP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    pkt_count <= pkt_count + LEN_W'(1);
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/stream_accel_engine.md
Name: stream_accel_engine

Overview:
Streaming compute stage between the HPS-to-FPGA FIFO source (fifo_0_out_*) and the FPGA-to-HPS FIFO sink (m2s_fifo_in_*) of the Computer_System. It consumes a header word and N data words on an Avalon-ST sink, then performs a reduction or element-wise operation. Results return on an Avalon-ST source, so HPS software can time the FPGA path against an equivalent HPS computation.

Parameters:
DATA_W, 32, stream data width
CH_W, 8, channel width
ERR_W, 8, error width
LEN_W, 16, packet length field width; also width of pkt_count

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  sink valid (from fifo_0_out_valid)
in_data  input  DATA_W  sink data
in_channel  input  CH_W  sink channel; ignored
in_error  input  ERR_W  sink error
in_ready  output  1  sink ready (to fifo_0_out_ready)
out_valid  output  1  source valid (to m2s_fifo_in_valid)
out_data  output  DATA_W  source data
out_channel  output  CH_W  opcode of the producing packet
out_error  output  ERR_W  status flags
out_ready  input  1  source ready (from m2s_fifo_in_ready)
busy  output  1  high whenever the FSM is not in IDLE
pkt_count  output  LEN_W  number of completed packets

Behaviour:
- Interface: one clock, clk; reset_n is asynchronous, active-low.
- Reset values: in_ready=0, out_valid=0, out_data=0, out_channel=0, out_error=0, busy=0, pkt_count=0, FSM=IDLE.
- Handshake protocol: Avalon-ST with ready latency 0. A transfer occurs on (valid && ready). While out_valid is high and out_ready is low, out_data, out_channel and out_error are held stable.
- Header word format: in_data[31:24] = opcode, in_data[LEN_W-1:0] = N, remaining bits ignored.
- Opcodes:
  - 0x01 SUM: modulo 2^32
  - 0x02 XOR
  - 0x03 MAX: unsigned
  - 0x04 MIN: unsigned
  - 0x10 ECHO_INC: each word is returned as word+1, modulo 2^32
  - Any other value is invalid.
- FSM states:
  - IDLE: in_ready=1. On header accept, latch opcode and N, clear the accumulator to its identity value (SUM/XOR/MAX → 0, MIN → 0xFFFFFFFF), clear err_sticky. If N=0, go to RESULT (ECHO with N=0 goes to DONE). Otherwise go to ACCUM (reductions and invalid opcodes) or ECHO.
  - ACCUM: in_ready=1. Each accepted word updates the accumulator and decrements the remaining count. Any nonzero in_error on an accepted word sets err_sticky. When the last word is accepted, go to RESULT.
  - RESULT: out_valid=1; out_data=accumulator (0 for an invalid opcode); out_channel=opcode; out_error[0]=invalid opcode, out_error[1]=err_sticky, other bits 0. On out_ready, go to DONE.
  - ECHO: single output register; in_ready = !out_valid || out_ready. An accepted word appears on out_data on the next cycle with out_channel=0x10 and out_error[1]=nonzero in_error of that word. After the Nth word is accepted, go to DRAIN.
  - DRAIN: in_ready=0; when the output register empties, go to DONE.
  - DONE: pkt_count increments (wraps from all-ones to 0); go to IDLE.
- Latency, reductions: N back-to-back words with the header accepted at cycle t → out_valid asserted at cycle t+N+1. N=0 → out_valid at t+1.
- Latency, ECHO: 1 cycle from input accept to out_valid. With out_ready held high, throughput is 1 word per cycle.
- in_ready is low in RESULT, DONE and DRAIN, so the next header is never consumed early.
- reset_n asserted mid-packet clears all state immediately; the partial packet is lost, and no output appears after release until a new header arrives.

Optional Feature:
STREAM_ACCEL_TIMESTAMP_EN
- Defined: a 32-bit cycle counter starts at header accept and stops at the last data accept (0 for N=0). After the RESULT word, or at the end of DRAIN, a second word is emitted before DONE: out_data = cycle count, out_channel = 0xFF, out_error = 0.
- Undefined: no counter exists, and each packet produces exactly one result word (or N echo words).

Test Plan:
- Header 0x01000004, then 1, 2, 3, 4 back-to-back, out_ready=1 → one word 0x0000000A, channel 0x01, error 0x00, at header cycle+5; pkt_count=1.
- Header 0x03000003, then 5, 0xFFFFFFFF, 3; out_ready low 4 cycles → out_data 0xFFFFFFFF held stable until accepted; in_ready=0 throughout the stall.
- Header 0x10000003, then 0x0, 0xFFFFFFFF, 7, with out_ready toggling every cycle → outputs 0x1, 0x0, 0x8 in order, none lost or duplicated, busy low after the last.
- Header 0x7F000002, then 2 words → single word, data 0, channel 0x7F, error 0x01. Header 0x04000000 → 0xFFFFFFFF on the next cycle.
- SUM packet with in_error=0x01 on word 2 → result error 0x02. reset_n pulsed after 2 of 4 words → all outputs return to 0, and a following SUM(10, 20) gives 0x0000001E.
- With STREAM_ACCEL_TIMESTAMP_EN: SUM of 4 back-to-back words → second word data 0x00000004, channel 0xFF.
